// File: rtl/posit_pack_encoder_if.sv
// posit_pack_encoder_if: valid/ready operand and result bus for the posit pack encoder
interface posit_pack_encoder_if #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
);
    logic          in_valid;
    logic          in_ready;
    logic          Sign;
    logic [RS:0]   Regime;
    logic [ES-1:0] Exponent;
    logic [N-1:0]  Fraction;
    logic          IsZero;
    logic          IsNaR;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  Out;
    modport master (
        output in_valid, Sign, Regime, Exponent, Fraction, IsZero, IsNaR, out_ready,
        input  in_ready, out_valid, Out
    );
    modport slave (
        input  in_valid, Sign, Regime, Exponent, Fraction, IsZero, IsNaR, out_ready,
        output in_ready, out_valid, Out
    );
endinterface

// File: rtl/posit_pack_encoder.sv
// posit_pack_encoder: two-stage valid/ready posit packer (regime build, then truncate/round, saturate, negate); ROUND_NEAREST_EVEN_EN enables round-to-nearest-even
module posit_pack_encoder #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input logic               clk,
    input logic               rst_n,
    posit_pack_encoder_if.slave io
);
    localparam int BW  = 2 * N;
    localparam int M   = N - 1;
    localparam int PAD = BW - 2 - ES - N;
`ifdef ROUND_NEAREST_EVEN_EN
    localparam int KW  = BW;
`else
    localparam int KW  = M;
`endif
    localparam logic signed [RS:0] SAT_HI = (RS + 1)'(N - 2);
    localparam logic signed [RS:0] SAT_LO = (RS + 1)'(2 - N);

    logic          s1_valid_q, s1_valid_d;
    logic [KW-1:0] s1_body_q, s1_body_d;
    logic          s1_sign_q, s1_sign_d;
    logic          s1_zero_q, s1_zero_d;
    logic          s1_nar_q, s1_nar_d;
    logic          s1_sat_hi_q, s1_sat_hi_d;
    logic          s1_sat_lo_q, s1_sat_lo_d;
    logic          s2_valid_q, s2_valid_d;
    logic [N-1:0]  out_q, out_d;

    logic          s1_adv, in_rdy, in_fire;
    logic          fill;
    logic [RS:0]   shamt;
    logic [BW-1:0] seed_full;
    logic [KW-1:0] seed, body;
    logic          sat_hi, sat_lo;
    logic [M-1:0]  mag, mag_fin;
    logic [N-1:0]  pos_word, result;
`ifdef ROUND_NEAREST_EVEN_EN
    logic          guard, sticky, carry;
    logic [M-1:0]  mag_rnd;
`endif

    // Stage 1: the run is built by sign-filling an arithmetic right shift of {fill, ~fill, exp, frac}
    always_comb begin
        fill      = !io.Regime[RS];
        shamt     = io.Regime[RS] ? ~io.Regime : io.Regime;
        seed_full = {fill, ~fill, io.Exponent, io.Fraction, {PAD{1'b0}}};
        seed      = KW'(seed_full >> (BW - KW));
        body      = $unsigned($signed(seed) >>> shamt);
        sat_hi    = $signed(io.Regime) >= SAT_HI;
        sat_lo    = $signed(io.Regime) <= SAT_LO;
    end

    // Stage 2: keep the top N-1 body bits, optionally round, clamp, then apply sign and specials
    always_comb begin
        mag = s1_body_q[KW-1 -: M];
`ifdef ROUND_NEAREST_EVEN_EN
        guard            = s1_body_q[KW-1-M];
        sticky           = |s1_body_q[KW-2-M:0];
        {carry, mag_rnd} = {1'b0, mag} + {{M{1'b0}}, guard && (sticky || mag[0])};
        mag              = carry ? {M{1'b1}} : mag_rnd;
`endif
        mag_fin  = s1_sat_hi_q ? {M{1'b1}} : s1_sat_lo_q ? {{(M-1){1'b0}}, 1'b1} : mag;
        pos_word = {1'b0, mag_fin};
        result   = s1_nar_q ? {1'b1, {M{1'b0}}} : s1_zero_q ? '0 :
                   s1_sign_q ? -pos_word : pos_word;
    end

    // Handshake and next-state: each stage loads only when the stage after it can move
    always_comb begin
        s1_adv      = !s2_valid_q || io.out_ready;
        in_rdy      = !s1_valid_q || s1_adv;
        in_fire     = io.in_valid && in_rdy;
        s1_valid_d  = in_rdy ? io.in_valid : s1_valid_q;
        s1_body_d   = in_fire ? body : s1_body_q;
        s1_sign_d   = in_fire ? io.Sign : s1_sign_q;
        s1_zero_d   = in_fire ? io.IsZero : s1_zero_q;
        s1_nar_d    = in_fire ? io.IsNaR : s1_nar_q;
        s1_sat_hi_d = in_fire ? sat_hi : s1_sat_hi_q;
        s1_sat_lo_d = in_fire ? sat_lo : s1_sat_lo_q;
        s2_valid_d  = s1_adv ? s1_valid_q : s2_valid_q;
        out_d       = (s1_adv && s1_valid_q) ? result : out_q;
    end

    // Pipeline registers; reset empties both stages and clears Out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_body_q   <= '0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            s1_sat_hi_q <= 1'b0;
            s1_sat_lo_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_body_q   <= s1_body_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_nar_q    <= s1_nar_d;
            s1_sat_hi_q <= s1_sat_hi_d;
            s1_sat_lo_q <= s1_sat_lo_d;
            s2_valid_q  <= s2_valid_d;
            out_q       <= out_d;
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = s2_valid_q;
    assign io.Out       = out_q;
endmodule

// File: tb/tb_posit_pack_encoder.sv
// tb_posit_pack_encoder: directed checks of packing, saturation, rounding, back-pressure and reset
module tb_posit_pack_encoder;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    posit_pack_encoder_if #(.N(8), .ES(3)) bus ();

    posit_pack_encoder #(.N(8), .ES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] k, input logic [2:0] e,
                         input logic [7:0] f, input logic z, input logic n);
        bus.in_valid = 1'b1;
        bus.Sign     = s;
        bus.Regime   = k;
        bus.Exponent = e;
        bus.Fraction = f;
        bus.IsZero   = z;
        bus.IsNaR    = n;
    endtask

    task automatic single(input string tag, input logic s, input logic [3:0] k, input logic [2:0] e,
                          input logic [7:0] f, input logic z, input logic n, input logic [7:0] exp_out);
        bus.out_ready = 1'b1;
        drive(s, k, e, f, z, n);
        check1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check1({tag, "_lat1_valid"}, bus.out_valid, 1'b0);
        tick();
        check1({tag, "_lat2_valid"}, bus.out_valid, 1'b1);
        check8({tag, "_out"}, bus.Out, exp_out);
        tick();
        check1({tag, "_drained"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 4'd0, 3'd0, 8'd0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        check1("reset_out_valid", bus.out_valid, 1'b0);
        check8("reset_out", bus.Out, 8'h00);
        #2 rst_n = 1'b1;
        #1;
        check1("reset_in_ready", bus.in_ready, 1'b1);
        tick();

        single("k0_pos",     1'b0, 4'd0,  3'd0, 8'h00, 1'b0, 1'b0, 8'h40);
        single("k0_neg",     1'b1, 4'd0,  3'd0, 8'h00, 1'b0, 1'b0, 8'hC0);
        single("km1",        1'b0, 4'hF,  3'd0, 8'h00, 1'b0, 1'b0, 8'h20);
        single("k5_e7",      1'b0, 4'd5,  3'd7, 8'h00, 1'b0, 1'b0, 8'h7E);
        single("k6_sat",     1'b0, 4'd6,  3'd0, 8'h00, 1'b0, 1'b0, 8'h7F);
        single("k7_sat",     1'b0, 4'd7,  3'd5, 8'h3C, 1'b0, 1'b0, 8'h7F);
        single("km6_sat",    1'b0, 4'hA,  3'd0, 8'h00, 1'b0, 1'b0, 8'h01);
        single("km8_sat",    1'b0, 4'h8,  3'd7, 8'hFF, 1'b0, 1'b0, 8'h01);
        single("neg_k7",     1'b1, 4'd7,  3'd0, 8'h00, 1'b0, 1'b0, 8'h81);
        single("neg_km8",    1'b1, 4'h8,  3'd0, 8'h00, 1'b0, 1'b0, 8'hFF);
        single("km5_e5",     1'b0, 4'hB,  3'd5, 8'h00, 1'b0, 1'b0, 8'h03);
        single("k3_e2",      1'b0, 4'd3,  3'd2, 8'h80, 1'b0, 1'b0, 8'h79);
        single("nar_zero",   1'b0, 4'd2,  3'd1, 8'h55, 1'b1, 1'b1, 8'h80);
        single("nar_only",   1'b1, 4'd3,  3'd6, 8'hAA, 1'b0, 1'b1, 8'h80);
        single("zero_only",  1'b1, 4'd3,  3'd6, 8'hAA, 1'b1, 1'b0, 8'h00);
`ifdef ROUND_NEAREST_EVEN_EN
        single("rnd_up",     1'b0, 4'd0,  3'd0, 8'hE0, 1'b0, 1'b0, 8'h44);
        single("rnd_tie",    1'b0, 4'd0,  3'd0, 8'h60, 1'b0, 1'b0, 8'h42);
        single("rnd_nowrap", 1'b0, 4'd5,  3'd7, 8'hFF, 1'b0, 1'b0, 8'h7F);
`else
        single("rnd_up",     1'b0, 4'd0,  3'd0, 8'hE0, 1'b0, 1'b0, 8'h43);
        single("rnd_tie",    1'b0, 4'd0,  3'd0, 8'h60, 1'b0, 1'b0, 8'h41);
        single("rnd_nowrap", 1'b0, 4'd5,  3'd7, 8'hFF, 1'b0, 1'b0, 8'h7E);
`endif

        bus.out_ready = 1'b1;
        drive(1'b0, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        check1("stream_rdy1", bus.in_ready, 1'b1);
        drive(1'b0, 4'hF, 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        check1("stream_rdy2", bus.in_ready, 1'b1);
        check8("stream_out0", bus.Out, 8'h40);
        drive(1'b1, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check1("stream_valid1", bus.out_valid, 1'b1);
        check8("stream_out1", bus.Out, 8'h20);
        tick();
        check1("stream_valid2", bus.out_valid, 1'b1);
        check8("stream_out2", bus.Out, 8'hC0);
        tick();
        check1("stream_empty", bus.out_valid, 1'b0);

        bus.out_ready = 1'b0;
        drive(1'b0, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        check1("bp_rdy0", bus.in_ready, 1'b1);
        tick();
        drive(1'b0, 4'hF, 3'd0, 8'h00, 1'b0, 1'b0);
        check1("bp_rdy1", bus.in_ready, 1'b1);
        tick();
        drive(1'b1, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        check1("bp_full_rdy", bus.in_ready, 1'b0);
        check1("bp_valid", bus.out_valid, 1'b1);
        check8("bp_out0", bus.Out, 8'h40);
        tick();
        check1("bp_hold_rdy", bus.in_ready, 1'b0);
        check8("bp_out0_hold", bus.Out, 8'h40);
        bus.out_ready = 1'b1;
        #1;
        check1("bp_release_rdy", bus.in_ready, 1'b1);
        tick();
        drive(1'b0, 4'd6, 3'd0, 8'h00, 1'b0, 1'b0);
        check8("bp_out1", bus.Out, 8'h20);
        tick();
        bus.in_valid = 1'b0;
        check8("bp_out2", bus.Out, 8'hC0);
        tick();
        check1("bp_valid3", bus.out_valid, 1'b1);
        check8("bp_out3", bus.Out, 8'h7F);
        tick();
        check1("bp_empty", bus.out_valid, 1'b0);

        bus.out_ready = 1'b0;
        drive(1'b0, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd7, 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check1("rst_pre_valid", bus.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check1("rst_async_valid", bus.out_valid, 1'b0);
        check8("rst_async_out", bus.Out, 8'h00);
        tick();
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check1("rst_release_rdy", bus.in_ready, 1'b1);
        tick();
        check1("rst_no_stale1", bus.out_valid, 1'b0);
        tick();
        check1("rst_no_stale2", bus.out_valid, 1'b0);
        check8("rst_out_zero", bus.Out, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
